softmax_row_arbiter: RTL
========================

Name: softmax_row_arbiter

Overview:
- Shares one Softmax_control instance among N_REQ attention-head requesters.
- Arbitration is per row: round-robin grant, locked until the row's last beat.
- Drives the per-row config (length, scale_in, scale_out) into the shared unit and holds it stable.
- Routes each output row back to its originating head, in issue order, using an internal tag FIFO.

Parameters:
N_REQ, 4, number of requesting heads
DATA_W, 8, element width (signed in, unsigned out)
LEN_W, 10, row-length field width
TAG_DEPTH, 4, max rows in flight inside the softmax unit (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-head input beat valid
req_ready  out  N_REQ  per-head input beat accept
req_data  in  N_REQ*DATA_W  per-head signed score
req_last  in  N_REQ  per-head last beat of row
req_length  in  N_REQ*LEN_W  per-head row length (1..1023)
req_scale_in  in  N_REQ*5  per-head signed input scale
req_scale_out  in  N_REQ*4  per-head output scale
sm_length  out  LEN_W  config to softmax
sm_scale_in  out  5  config to softmax
sm_scale_out  out  4  config to softmax
sm_data_in  out  DATA_W  beat to softmax
sm_valid_in  out  1  beat valid to softmax
sm_ready_in  in  1  softmax accept
sm_last_in  out  1  last beat to softmax
sm_data_out  in  DATA_W  softmax result
sm_valid_out  in  1  result valid (no backpressure)
sm_last_out  in  1  result last
rsp_data  out  DATA_W  result to heads
rsp_valid  out  N_REQ  one-hot result valid
rsp_last  out  1  result last
err  out  1  sticky length/last mismatch
err_head  out  log2(N_REQ)  head that caused first error
busy  out  1  row streaming or rows in flight

Behaviour:
- Reset values:
  - req_ready=0, sm_valid_in=0, sm_last_in=0, rsp_valid=0, rsp_last=0, rsp_data=0.
  - sm_length/sm_scale_in/sm_scale_out=0.
  - err=0, err_head=0, busy=0.
  - RR pointer=0, tag FIFO empty, state IDLE.
  - Reset mid-row abandons the row; a partial row is never resumed.
- FSM states:
  - IDLE: when any req_valid is set and a grant is allowed -> ARB.
  - ARB (1 cycle): choose the first head with req_valid, searching from RR pointer upward with wrap. Latch that head's length/scale_in/scale_out into the sm_* config registers. Push the head index to the tag FIFO. Load beat counter=0. -> STREAM.
  - STREAM:
    - Mux the granted head combinationally: sm_data_in=req_data[g]; sm_valid_in=req_valid[g].
    - req_ready[g]=sm_ready_in; all other req_ready=0.
    - sm_last_in asserts when beat counter==sm_length-1.
    - Each sm_valid_in&sm_ready_in increments the counter.
    - On the accepted beat with counter==sm_length-1: RR pointer=g+1 mod N_REQ -> IDLE.
- Grant allowed when the tag FIFO is not full AND either:
  - the FIFO is empty, or
  - the candidate's {length,scale_in,scale_out} equals the latched config.
  - Otherwise wait in IDLE until sm_last_out drains the FIFO.
  - This guarantees config stays stable over every in-flight row.
- Config registers change only in ARB. They are held through STREAM and until the next ARB.
- Length/last checking, on an accepted beat:
  - req_last[g]=1 with counter!=sm_length-1 -> set err.
  - counter==sm_length-1 with req_last[g]=0 -> set err.
  - The row still terminates at sm_length beats.
  - err_head is captured only on the first error. err clears only on reset.
- Response routing:
  - Registered, 1-cycle latency: rsp_data<=sm_data_out; rsp_valid<=onehot(fifo_head)&{N{sm_valid_out}}; rsp_last<=sm_last_out&sm_valid_out.
  - Pop the FIFO on sm_valid_out&sm_last_out.
  - sm_valid_out with an empty FIFO is ignored: rsp_valid=0, err set, err_head=0.
- Simultaneous push (ARB) and pop (sm_last_out) in one cycle: occupancy unchanged.
- busy = (state!=IDLE) | FIFO not empty.
- Tie/fairness: a head just served has lowest priority next ARB. A single requester may be granted back-to-back.

Test Plan:
- Single head: head 0 sends a 197-beat row of value 100, length=197, scale_in=6, scale_out=7 -> sm_last_in on beat 197; 197 rsp beats with rsp_valid=4'b0001; rsp_last on the 197th; busy falls after it.
- All 4 heads valid, identical config, 8-beat rows -> grant order 0,1,2,3,0; rows overlap inside softmax up to 4 in flight; each rsp row goes to the correct one-hot head in issue order.
- Config mismatch: head 1 has scale_out=8 while head 0's row (scale_out=7) is in flight -> head 1 not granted until head 0's sm_last_out; sm_scale_out stays 7 throughout head 0's output.
- Backpressure: sm_ready_in toggles every cycle -> req_ready[g] mirrors it; no beat is lost or duplicated; the beat counter ends at length.
- Early req_last on beat 5 of a length-8 row -> err=1, err_head=g; the row still sends 8 beats.
- Assert rst_n low mid-STREAM -> all outputs return to reset values immediately; after release, a new row starts from ARB with the FIFO empty.

Source files
------------

// File: rtl/softmax_row_arbiter.sv
// Row-granular round-robin arbiter that shares one softmax unit among N_REQ heads,
// holds the per-row config stable and steers each result row back to its issuing head.
module softmax_row_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int LEN_W     = 10,
  parameter int TAG_DEPTH = 4,
  localparam int HW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  input  logic [N_REQ*LEN_W-1:0]    req_length,
  input  logic [N_REQ*5-1:0]        req_scale_in,
  input  logic [N_REQ*4-1:0]        req_scale_out,
  output logic [LEN_W-1:0]          sm_length,
  output logic [4:0]                sm_scale_in,
  output logic [3:0]                sm_scale_out,
  output logic [DATA_W-1:0]         sm_data_in,
  output logic                      sm_valid_in,
  input  logic                      sm_ready_in,
  output logic                      sm_last_in,
  input  logic [DATA_W-1:0]         sm_data_out,
  input  logic                      sm_valid_out,
  input  logic                      sm_last_out,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic                      rsp_last,
  output logic                      err,
  output logic [HW-1:0]             err_head,
  output logic                      busy
);

  localparam int AW = $clog2(TAG_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(TAG_DEPTH);

  typedef enum logic [1:0] {IDLE, ARB, STREAM} state_t;

  state_t state, state_nxt;

  logic [HW-1:0]     rr_ptr;
  logic [HW-1:0]     grant;
  logic [HW-1:0]     cand;
  logic              cand_found;
  logic              cfg_match;
  logic              grant_ok;
  logic [LEN_W-1:0]  beat_cnt;
  logic [LEN_W-1:0]  len_m1;
  logic              is_last_beat;
  logic              accept;
  logic              stream_err;
  logic              orphan;

  logic [LEN_W-1:0]  len_a  [N_REQ];
  logic [4:0]        sin_a  [N_REQ];
  logic [3:0]        sout_a [N_REQ];
  logic [DATA_W-1:0] data_a [N_REQ];

  logic [HW-1:0]     tag_mem [TAG_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       fifo_cnt;
  logic              fifo_empty, fifo_full;
  logic              push, pop;
  logic [N_REQ-1:0]  head_onehot;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign len_a[i]  = req_length[i*LEN_W +: LEN_W];
    assign sin_a[i]  = req_scale_in[i*5 +: 5];
    assign sout_a[i] = req_scale_out[i*4 +: 4];
    assign data_a[i] = req_data[i*DATA_W +: DATA_W];
  end

  // First valid head at or after the RR pointer, wrapping around.
  always_comb begin
    int idx;
    cand       = '0;
    cand_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!cand_found && req_valid[idx]) begin
        cand_found = 1'b1;
        cand       = HW'(idx);
      end
    end
  end

  // A new row may only join rows already in flight if it uses the same config.
  assign cfg_match    = ({len_a[cand], sin_a[cand], sout_a[cand]} ==
                         {sm_length, sm_scale_in, sm_scale_out});
  assign grant_ok     = cand_found && !fifo_full && (fifo_empty || cfg_match);
  assign len_m1       = sm_length - LEN_W'(1);
  assign is_last_beat = (beat_cnt == len_m1);
  assign accept       = (state == STREAM) && req_valid[grant] && sm_ready_in;
  assign stream_err   = accept && (req_last[grant] != is_last_beat);
  assign orphan       = sm_valid_out && fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    sm_valid_in = 1'b0;
    sm_data_in  = '0;
    sm_last_in  = 1'b0;
    case (state)
      IDLE:   if (grant_ok) state_nxt = ARB;
      ARB:    state_nxt = STREAM;
      STREAM: begin
        req_ready[grant] = sm_ready_in;
        sm_valid_in      = req_valid[grant];
        sm_data_in       = data_a[grant];
        sm_last_in       = is_last_beat;
        if (accept && is_last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, config latch, beat counter and fairness pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      grant        <= '0;
      beat_cnt     <= '0;
      sm_length    <= '0;
      sm_scale_in  <= '0;
      sm_scale_out <= '0;
    end else begin
      if (state == IDLE && grant_ok) grant <= cand;
      if (state == ARB) begin
        sm_length    <= len_a[grant];
        sm_scale_in  <= sin_a[grant];
        sm_scale_out <= sout_a[grant];
        beat_cnt     <= '0;
      end
      if (accept) begin
        beat_cnt <= beat_cnt + LEN_W'(1);
        if (is_last_beat)
          rr_ptr <= (grant == HW'(N_REQ-1)) ? '0 : grant + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err      <= 1'b0;
      err_head <= '0;
    end else if (!err) begin
      if (stream_err) begin
        err      <= 1'b1;
        err_head <= grant;
      end else if (orphan) begin
        err      <= 1'b1;
        err_head <= '0;
      end
    end
  end

  // Tag FIFO: one entry per row issued, popped when that row's last result leaves.
  assign push        = (state == ARB);
  assign pop         = sm_valid_out && sm_last_out && !fifo_empty;
  assign fifo_empty  = (fifo_cnt == '0);
  assign fifo_full   = (fifo_cnt == DEPTH_C);
  assign head_onehot = N_REQ'(1) << tag_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data  <= '0;
      rsp_valid <= '0;
      rsp_last  <= 1'b0;
    end else begin
      rsp_data  <= sm_data_out;
      rsp_valid <= fifo_empty ? '0 : (head_onehot & {N_REQ{sm_valid_out}});
      rsp_last  <= sm_valid_out && sm_last_out && !fifo_empty;
    end
  end

  assign busy = (state != IDLE) || !fifo_empty;

endmodule
